// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S serializer with a single-entry holding register.
// Accepts stereo PCM pairs over valid/ready and emits BCLK/LRCLK/SDATA,
// MSB first, with LRCLK leading each channel's MSB by one bit period.
module i2s_tx #(
    parameter int SAMPLE_W = 16,
    parameter int CLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                underrun
);

    localparam int FRAME_BITS = 2 * SAMPLE_W;
    localparam int BW         = $clog2(FRAME_BITS);
    localparam int DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DW-1:0]         div_q;
    logic                  bclk_q;
    logic [BW-1:0]         b_q;
    logic [BW-1:0]         b_inc;
    logic                  lr_q;
    logic                  lr_next;
    logic [FRAME_BITS-1:0] shift_q;
    logic                  underrun_q;
    logic                  full_q;
    logic [SAMPLE_W-1:0]   hold_l_q;
    logic [SAMPLE_W-1:0]   hold_r_q;

    logic busy;
    logic tick;
    logic fall;
    logic last;
    logic xfer;

    // Control strobes decoded from the FSM and the bit timing.
    logic start;
    logic wrap;
    logic stop;
    logic load;
    logic adv;

    assign busy  = (state_q != IDLE);
    assign tick  = (div_q == DW'(CLK_DIV - 1));
    assign fall  = busy & tick & bclk_q;
    assign last  = (b_q == BW'(FRAME_BITS - 1));
    assign xfer  = sample_valid & ~full_q;
    assign b_inc = b_q + BW'(1);

    // LRCLK goes high one slot before the right MSB and low one slot
    // before the left MSB, giving the I2S one-bit delay.
    assign lr_next = (b_inc >= BW'(SAMPLE_W - 1)) && (b_inc <= BW'(FRAME_BITS - 2));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: RUN keeps framing, DRAIN finishes the current frame.
    always_comb begin
        // NOTE: the default assignment up front keeps this purely
        // combinational; without it an unassigned path would infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) state_d = DRAIN;
            end
            DRAIN: begin
                if (enable) state_d = RUN;
                else if (fall && last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: when to load a frame, advance a bit or shut down.
    always_comb begin
        start = 1'b0;
        wrap  = 1'b0;
        stop  = 1'b0;
        load  = 1'b0;
        adv   = 1'b0;
        if (state_q == IDLE) begin
            start = enable;
        end else if (fall) begin
            if (!last) begin
                adv = 1'b1;
            end else if (state_q == DRAIN && !enable) begin
                stop = 1'b1;
            end else begin
                wrap = 1'b1;
            end
        end
        load = start | wrap;
    end

    // Bit-clock divider, frame shifter, LRCLK, underrun and occupancy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            bclk_q     <= 1'b0;
            b_q        <= '0;
            lr_q       <= 1'b0;
            shift_q    <= '0;
            underrun_q <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            underrun_q <= load & ~full_q;

            if (start || stop) begin
                div_q  <= '0;
                bclk_q <= 1'b0;
            end else if (busy) begin
                if (tick) begin
                    div_q  <= '0;
                    bclk_q <= ~bclk_q;
                end else begin
                    div_q <= div_q + DW'(1);
                end
            end

            if (load) begin
                b_q     <= '0;
                lr_q    <= 1'b0;
                shift_q <= full_q ? {hold_l_q, hold_r_q} : '0;
            end else if (adv) begin
                b_q     <= b_inc;
                lr_q    <= lr_next;
                shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
            end else if (stop) begin
                b_q     <= '0;
                lr_q    <= 1'b0;
                shift_q <= '0;
            end

            // A transfer only happens while empty, so it never collides
            // with a load that drains a full register.
            if (xfer) begin
                full_q <= 1'b1;
            end else if (load) begin
                full_q <= 1'b0;
            end
        end
    end

    // Holding register data capture.
    // NOTE: the data words carry no reset; full_q alone says whether they
    // are meaningful, so clearing them on reset would buy nothing.
    always_ff @(posedge clk) begin
        if (xfer) begin
            hold_l_q <= sample_l;
            hold_r_q <= sample_r;
        end
    end

    assign sample_ready = ~full_q;
    assign bclk         = bclk_q;
    assign lrclk        = lr_q;
    assign sdata        = shift_q[FRAME_BITS-1];
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench for i2s_tx. Expected frames are queued when
// stimulus is driven and compared when the serial stream completes a frame.
module tb_i2s_tx;

    localparam int W         = 16;
    localparam int D         = 4;
    localparam int FB        = 2 * W;
    localparam int FRAME_CYC = 4 * W * D;
    localparam int W2        = 8;
    localparam int D2        = 1;
    localparam int FB2       = 2 * W2;
    localparam int BUDGET    = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Default-parameter instance
    logic         enable = 1'b0;
    logic [W-1:0] sample_l = '0;
    logic [W-1:0] sample_r = '0;
    logic         sample_valid = 1'b0;
    logic         sample_ready;
    logic         bclk;
    logic         lrclk;
    logic         sdata;
    logic         underrun;

    // Small-parameter instance
    logic          enable_b = 1'b0;
    logic [W2-1:0] l_b = '0;
    logic [W2-1:0] r_b = '0;
    logic          valid_b = 1'b0;
    logic          ready_b;
    logic          bclk_b;
    logic          lrclk_b;
    logic          sdata_b;
    logic          underrun_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    i2s_tx #(.SAMPLE_W(W), .CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .sample_l(sample_l), .sample_r(sample_r),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun)
    );

    i2s_tx #(.SAMPLE_W(W2), .CLK_DIV(D2)) dut_b (
        .clk(clk), .rst(rst), .enable(enable_b),
        .sample_l(l_b), .sample_r(r_b),
        .sample_valid(valid_b), .sample_ready(ready_b),
        .bclk(bclk_b), .lrclk(lrclk_b), .sdata(sdata_b), .underrun(underrun_b)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard and stream monitor for the default instance
    logic [FB-1:0] exp_q[$];
    logic [FB-1:0] mon_bits = '0;
    logic [FB-1:0] exp_frame;
    logic          mon_cur = 1'b0;
    logic          bclk_prev = 1'b0;
    logic          exp_lr;
    int mon_idx = 0;
    int first_rise = -1;
    int last_fall = 0;
    int last_bit_rise = 0;
    int last_gap = 0;
    int urun_cnt = 0;
    int urun_last = 0;
    int urun_gap = 0;
    int frames_seen = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            mon_idx   = 0;
            bclk_prev = 1'b0;
        end else begin
            if (underrun) begin
                urun_gap  = cyc - urun_last;
                urun_last = cyc;
                urun_cnt++;
            end
            if (bclk && !bclk_prev) begin
                if (first_rise < 0) first_rise = cyc;
                if (mon_idx == 0) last_gap = cyc - last_bit_rise;
                exp_lr = (mon_idx >= W - 1) && (mon_idx <= FB - 2);
                checks++;
                if (lrclk !== exp_lr) begin
                    errors++;
                    $display("FAIL lrclk_slot b=%0d: got %b expected %b", mon_idx, lrclk, exp_lr);
                end
                mon_bits = {mon_bits[FB-2:0], sdata};
                mon_cur  = sdata;
                if (mon_idx == FB - 1) begin
                    last_bit_rise = cyc;
                    mon_idx = 0;
                    frames_seen++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_data: got unexpected frame %h, expected none", mon_bits);
                    end else begin
                        exp_frame = exp_q.pop_front();
                        if (mon_bits !== exp_frame) begin
                            errors++;
                            $display("FAIL frame_data: got %h expected %h", mon_bits, exp_frame);
                        end
                    end
                end else begin
                    mon_idx++;
                end
            end else if (bclk && bclk_prev) begin
                checks++;
                if (sdata !== mon_cur) begin
                    errors++;
                    $display("FAIL sdata_stable: got %b expected %b while bclk high", sdata, mon_cur);
                end
            end
            if (!bclk && bclk_prev) last_fall = cyc;
            bclk_prev = bclk;
        end
    end

    // Stream capture for the small instance
    logic [FB2-1:0] bits_b = '0;
    logic [FB2-1:0] lr_vec_b = '0;
    logic           bprev_b = 1'b0;
    int nbits_b = 0;
    int first_rise_b = -1;
    int last_fall_b = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            bprev_b = 1'b0;
        end else begin
            if (bclk_b && !bprev_b) begin
                if (first_rise_b < 0) first_rise_b = cyc;
                if (nbits_b < FB2) begin
                    bits_b = {bits_b[FB2-2:0], sdata_b};
                    lr_vec_b[nbits_b] = lrclk_b;
                end
                nbits_b++;
            end
            if (!bclk_b && bprev_b) last_fall_b = cyc;
            bprev_b = bclk_b;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        int n = 0;
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        while (sample_ready !== 1'b1 && n < BUDGET) begin
            step();
            n++;
        end
        checks++;
        if (n >= BUDGET) begin
            errors++;
            $display("FAIL push_timeout: ready stayed %b, expected 1", sample_ready);
        end
        exp_q.push_back({l, r});
        step();
        sample_valid = 1'b0;
        checks++;
        if (sample_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_drop: got %b expected 0 after accept", sample_ready);
        end
    endtask

    task automatic wait_idx(input int target);
        int n = 0;
        while (mon_idx != target && n < BUDGET) begin
            step();
            n++;
        end
        checks++;
        if (n >= BUDGET) begin
            errors++;
            $display("FAIL wait_bit: bit index %0d, expected %0d", mon_idx, target);
        end
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 4 * FRAME_CYC) begin
            step();
            n++;
        end
        checks++;
        if (n >= 4 * FRAME_CYC) begin
            errors++;
            $display("FAIL wait_frames: %0d frames pending, expected 0", exp_q.size());
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (sample_ready !== 1'b1 && n < 2 * FRAME_CYC) begin
            step();
            n++;
        end
        checks++;
        if (n >= 2 * FRAME_CYC) begin
            errors++;
            $display("FAIL wait_ready: ready %b, expected 1", sample_ready);
        end
    endtask

    task automatic check_quiet(input int n, input string name);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if ({bclk, lrclk, sdata, underrun} !== 4'b0000) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d cycles with active outputs, expected 0", name, bad);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bclk, lrclk, sdata, underrun, sample_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_a: got bclk/lrclk/sdata/underrun/ready=%b expected 00001",
                     {bclk, lrclk, sdata, underrun, sample_ready});
        end
        checks++;
        if ({bclk_b, lrclk_b, sdata_b, underrun_b, ready_b} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_b: got %b expected 00001",
                     {bclk_b, lrclk_b, sdata_b, underrun_b, ready_b});
        end
        steps(3);
        rst = 1'b0;
        check_quiet(100, "idle_after_reset");
    endtask

    task automatic test_single_frame();
        int u0;
        push_pair(16'hA5F0, 16'h0F5A);
        u0 = urun_cnt;
        first_rise = -1;
        enable = 1'b1;
        wait_idx(5);
        enable = 1'b0;
        wait_empty();
        steps(2 * D + 2);
        checks++;
        if (last_fall - first_rise != FRAME_CYC - D) begin
            errors++;
            $display("FAIL frame_length: got %0d expected %0d",
                     last_fall - first_rise + D, FRAME_CYC);
        end
        checks++;
        if (urun_cnt != u0) begin
            errors++;
            $display("FAIL single_underrun: got %0d pulses expected 0", urun_cnt - u0);
        end
        checks++;
        if (sample_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b expected 1", sample_ready);
        end
        check_quiet(50, "idle_after_single");
    endtask

    task automatic test_backpressure();
        localparam int NP = 4;
        int u0;
        int f0;
        int prev_acc = 0;
        int n;
        u0 = urun_cnt;
        f0 = frames_seen;
        for (int k = 0; k < NP; k++) begin
            sample_l     = 16'h1100 + 16'(k);
            sample_r     = 16'h2200 + 16'(k);
            sample_valid = 1'b1;
            n = 0;
            while (sample_ready !== 1'b1 && n < 2 * FRAME_CYC) begin
                step();
                n++;
            end
            if (k >= 2) begin
                checks++;
                if (cyc != last_fall) begin
                    errors++;
                    $display("FAIL ready_rise: ready at cycle %0d expected %0d", cyc, last_fall);
                end
                checks++;
                if (cyc - prev_acc != FRAME_CYC) begin
                    errors++;
                    $display("FAIL accept_spacing: got %0d expected %0d", cyc - prev_acc, FRAME_CYC);
                end
            end
            prev_acc = cyc;
            exp_q.push_back({sample_l, sample_r});
            step();
            checks++;
            if (sample_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready_drop: got %b expected 0", sample_ready);
            end
            if (k == 0) enable = 1'b1;
        end
        sample_valid = 1'b0;
        wait_ready();
        enable = 1'b0;
        wait_empty();
        steps(2 * D + 2);
        checks++;
        if (frames_seen - f0 != NP || urun_cnt != u0) begin
            errors++;
            $display("FAIL bp_count: got %0d frames %0d underruns expected %0d frames 0 underruns",
                     frames_seen - f0, urun_cnt - u0, NP);
        end
    endtask

    task automatic test_underrun();
        int u0;
        int n = 0;
        u0 = urun_cnt;
        for (int i = 0; i < 3; i++) exp_q.push_back('0);
        enable = 1'b1;
        for (int p = 2; p <= 3; p++) begin
            while (urun_cnt != u0 + p && n < 4 * FRAME_CYC) begin
                step();
                n++;
            end
            checks++;
            if (urun_gap != FRAME_CYC) begin
                errors++;
                $display("FAIL underrun_spacing: got %0d expected %0d", urun_gap, FRAME_CYC);
            end
        end
        push_pair(16'h8000, 16'h7FFF);
        wait_ready();
        enable = 1'b0;
        wait_empty();
        steps(2 * D + 2);
        checks++;
        if (urun_cnt != u0 + 3) begin
            errors++;
            $display("FAIL underrun_count: got %0d expected 3", urun_cnt - u0);
        end
    endtask

    task automatic test_enable_drop();
        int u0;
        push_pair(16'hC3A5, 16'h5A3C);
        first_rise = -1;
        enable = 1'b1;
        wait_idx(5);
        enable = 1'b0;
        wait_empty();
        steps(2 * D + 2);
        checks++;
        if (last_fall - first_rise != FRAME_CYC - D) begin
            errors++;
            $display("FAIL drain_length: got %0d expected %0d",
                     last_fall - first_rise + D, FRAME_CYC);
        end
        check_quiet(50, "idle_after_drain");

        push_pair(16'h1234, 16'h5678);
        u0 = urun_cnt;
        enable = 1'b1;
        steps(2);
        push_pair(16'h9ABC, 16'hDEF0);
        wait_idx(2);
        enable = 1'b0;
        wait_idx(20);
        enable = 1'b1;
        wait_empty();
        enable = 1'b0;
        checks++;
        if (last_gap != 2 * D) begin
            errors++;
            $display("FAIL reenable_gap: got %0d expected %0d", last_gap, 2 * D);
        end
        steps(2 * D + 2);
        checks++;
        if (urun_cnt != u0) begin
            errors++;
            $display("FAIL reenable_underrun: got %0d expected 0", urun_cnt - u0);
        end
        check_quiet(30, "idle_after_reenable");
    endtask

    task automatic test_params();
        logic [FB2-1:0] exp_lr_b;
        int n = 0;
        for (int b = 0; b < FB2; b++) exp_lr_b[b] = (b >= W2 - 1) && (b <= FB2 - 2);
        l_b     = 8'h81;
        r_b     = 8'h7E;
        valid_b = 1'b1;
        while (ready_b !== 1'b1 && n < BUDGET) begin
            step();
            n++;
        end
        step();
        valid_b = 1'b0;
        nbits_b = 0;
        first_rise_b = -1;
        enable_b = 1'b1;
        step();
        enable_b = 1'b0;
        steps(40);
        checks++;
        if (nbits_b != FB2) begin
            errors++;
            $display("FAIL small_bits: got %0d bits expected %0d", nbits_b, FB2);
        end
        checks++;
        if (bits_b !== 16'h817E) begin
            errors++;
            $display("FAIL small_data: got %h expected 817e", bits_b);
        end
        checks++;
        if (lr_vec_b !== exp_lr_b) begin
            errors++;
            $display("FAIL small_lrclk: got %b expected %b", lr_vec_b, exp_lr_b);
        end
        checks++;
        if (last_fall_b - first_rise_b != 4 * W2 * D2 - D2) begin
            errors++;
            $display("FAIL small_length: got %0d expected %0d",
                     last_fall_b - first_rise_b + D2, 4 * W2 * D2);
        end
    endtask

    task automatic test_reset_midframe();
        int u0;
        push_pair(16'hFFFF, 16'hFFFF);
        enable = 1'b1;
        steps(2);
        push_pair(16'h1111, 16'h2222);
        wait_idx(10);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bclk, lrclk, sdata, underrun, sample_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_async: got %b expected 00001",
                     {bclk, lrclk, sdata, underrun, sample_ready});
        end
        exp_q.delete();
        enable = 1'b0;
        steps(3);
        rst = 1'b0;
        check_quiet(100, "idle_after_midreset");
        u0 = urun_cnt;
        exp_q.push_back('0);
        enable = 1'b1;
        step();
        enable = 1'b0;
        wait_empty();
        steps(2 * D + 2);
        checks++;
        if (urun_cnt != u0 + 1) begin
            errors++;
            $display("FAIL reset_discard: got %0d underruns expected 1", urun_cnt - u0);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_underrun();
        test_enable_drop();
        test_params();
        test_reset_midframe();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_frames: got %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
